// File: rtl/ecg_pkg.sv
// ecg_pkg: shared types, default parameter constants and width helper for
// the ECG buffer address generator and its counter.
package ecg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROC  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } ecg_state_t;

  localparam int DEF_AW     = 12;
  localparam int DEF_DEPTH  = 2048;
  localparam int DEF_NCH    = 2;
  localparam int DEF_LAG    = 2;
  localparam int DEF_STAGES = 6;

  // Bits needed to count 0..value-1; never less than one so that a
  // degenerate range (value of 1) still yields a legal vector.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ecg_stage_ctr.sv
// ecg_stage_ctr: wrapping stage -> index -> channel cascade counter.
// With i_stage_bypass high the stage digit is skipped so that every enabled
// cycle advances the index directly (sample loading); with it low each index
// value is held for STAGES cycles (processing). The counter wraps to zero
// after its terminal count, so the next phase always starts from the origin.
module ecg_stage_ctr
  import ecg_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NCH    = DEF_NCH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_stage_bypass,
  output logic [clog2_f(STAGES)-1:0]   o_stage,
  output logic [clog2_f(DEPTH)-1:0]    o_idx,
  output logic [clog2_f(NCH)-1:0]      o_ch,
  output logic                         o_idx_tc,
  output logic                         o_last
);

  localparam int SW = clog2_f(STAGES);
  localparam int IW = clog2_f(DEPTH);
  localparam int CW = clog2_f(NCH);

  logic [SW-1:0] r_stage;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_ch;
  logic          w_stage_tc;
  logic          w_idx_tc;
  logic          w_ch_tc;

  assign w_stage_tc = i_stage_bypass || (r_stage == SW'(STAGES - 1));
  assign w_idx_tc   = (r_idx == IW'(DEPTH - 1));
  assign w_ch_tc    = (r_ch == CW'(NCH - 1));

  assign o_stage  = r_stage;
  assign o_idx    = r_idx;
  assign o_ch     = r_ch;
  assign o_idx_tc = w_stage_tc && w_idx_tc;
  assign o_last   = w_stage_tc && w_idx_tc && w_ch_tc;

  // Cascade: stage wraps into index, index wraps into channel, channel wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_idx   <= '0;
      r_ch    <= '0;
    end else if (i_en) begin
      if (w_stage_tc) begin
        r_stage <= '0;
        if (w_idx_tc) begin
          r_idx <= '0;
          r_ch  <= w_ch_tc ? '0 : r_ch + 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_stage <= r_stage + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecg_addr_gen.sv
// ecg_addr_gen: frame sequencer for a dual-port ECG sample buffer.
// A frame loads NCH*DEPTH samples, sweeps every sample through STAGES
// processing slots (port B trails port A by LAG samples inside the same
// channel region), then streams result-memory fetch addresses.
// Build option: define ECG_ADDR_GEN_CONT_EN for continuous framing, where
// DONE returns straight to LOAD and only the first frame needs start.
module ecg_addr_gen
  import ecg_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NCH    = DEF_NCH,
  parameter int LAG    = DEF_LAG,
  parameter int STAGES = DEF_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] addra,
  output logic [AW-1:0] addrb,
  output logic          wea,
  output logic [2:0]    stage,
  output logic [2:0]    ch,
  output logic [AW-1:0] m2_addr,
  output logic          m2_valid,
  input  logic          m2_ready,
  output logic          switch,
  output logic          done
);

  localparam int SW = clog2_f(STAGES);
  localparam int IW = clog2_f(DEPTH);
  localparam int CW = clog2_f(NCH);

  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCH * DEPTH - 1);
  localparam logic [IW-1:0] LAG_I     = IW'(LAG);

  ecg_state_t    r_state;
  ecg_state_t    w_state_nxt;
  logic [AW-1:0] r_m2_addr;

  logic          w_accept;
  logic          w_ctr_en;
  logic          w_ctr_bypass;
  logic [SW-1:0] w_stage;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_ch;
  logic          w_idx_tc;
  logic          w_last;
  logic          w_fetch_hs;
  logic [IW-1:0] w_lag_idx;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_row_a;
  logic [AW-1:0] w_row_b;

  assign w_accept     = (r_state == ST_LOAD) && in_valid;
  assign w_ctr_en     = w_accept || (r_state == ST_PROC);
  assign w_ctr_bypass = (r_state != ST_PROC);
  assign w_fetch_hs   = (r_state == ST_FETCH) && m2_ready;

  // The index subtraction is done at index width so the lagged address
  // wraps inside its own channel region instead of borrowing from the
  // channel bits.
  assign w_lag_idx = w_idx - LAG_I;
  assign w_base    = AW'(w_ch) * DEPTH_A;
  assign w_row_a   = w_base + AW'(w_idx);
  assign w_row_b   = w_base + AW'(w_lag_idx);

  // One counter serves both the load write pointer and the processing sweep.
  ecg_stage_ctr #(
    .STAGES (STAGES),
    .DEPTH  (DEPTH),
    .NCH    (NCH)
  ) u_ctr (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (w_ctr_en),
    .i_stage_bypass (w_ctr_bypass),
    .o_stage        (w_stage),
    .o_idx          (w_idx),
    .o_ch           (w_ch),
    .o_idx_tc       (w_idx_tc),
    .o_last         (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (w_accept && w_last) w_state_nxt = ST_PROC;
      ST_PROC:  if (w_last) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_fetch_hs && (r_m2_addr == LAST_ADDR)) w_state_nxt = ST_DONE;
`ifdef ECG_ADDR_GEN_CONT_EN
      ST_DONE:  w_state_nxt = ST_LOAD;
`else
      ST_DONE:  w_state_nxt = ST_IDLE;
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; everything idles at zero outside the state that owns it.
  always_comb begin
    in_ready = 1'b0;
    wea      = 1'b0;
    addra    = '0;
    addrb    = '0;
    stage    = '0;
    ch       = '0;
    m2_valid = 1'b0;
    switch   = 1'b0;
    done     = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        wea      = in_valid;
        addra    = w_row_a;
        ch       = 3'(w_ch);
      end
      ST_PROC: begin
        switch = 1'b1;
        addra  = w_row_a;
        addrb  = w_row_b;
        stage  = 3'(w_stage);
        ch     = 3'(w_ch);
      end
      ST_FETCH: begin
        switch   = 1'b1;
        m2_valid = 1'b1;
      end
      ST_DONE: begin
        switch = 1'b1;
        done   = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Result fetch pointer: advances only on an accepted fetch and wraps to 0
  // after the last address so the next frame starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m2_addr <= '0;
    end else if (w_fetch_hs) begin
      r_m2_addr <= (r_m2_addr == LAST_ADDR) ? '0 : r_m2_addr + 1'b1;
    end
  end

  assign m2_addr = r_m2_addr;

endmodule

// File: tb/tb_ecg_addr_gen.sv
// tb_ecg_addr_gen: scoreboard bench for ecg_addr_gen with NCH=2, DEPTH=8,
// LAG=2, STAGES=6. Stimulus queues expected events and per-cycle snapshots;
// a monitor on the falling edge pops and compares them.
module tb_ecg_addr_gen;

  localparam int AW     = 12;
  localparam int DEPTH  = 8;
  localparam int NCH    = 2;
  localparam int LAG    = 2;
  localparam int STAGES = 6;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] addra;
  logic [AW-1:0] addrb;
  logic          wea;
  logic [2:0]    stage;
  logic [2:0]    ch;
  logic [AW-1:0] m2_addr;
  logic          m2_valid;
  logic          m2_ready;
  logic          switch;
  logic          done;

  ecg_addr_gen #(
    .AW(AW), .DEPTH(DEPTH), .NCH(NCH), .LAG(LAG), .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addra    (addra),
    .addrb    (addrb),
    .wea      (wea),
    .stage    (stage),
    .ch       (ch),
    .m2_addr  (m2_addr),
    .m2_valid (m2_valid),
    .m2_ready (m2_ready),
    .switch   (switch),
    .done     (done)
  );

  typedef struct packed {
    logic [1:0]  k;   // 0 write, 1 proc, 2 fetch, 3 done
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  st;
    logic [2:0]  c;
  } ev_t;

  typedef struct packed {
    logic        ir;
    logic        we;
    logic        sw;
    logic        mv;
    logic        dn;
    logic [2:0]  st;
    logic [2:0]  c;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] m;
  } snap_t;

  ev_t   evq[$];
  snap_t snapq[$];
  string snapn[$];

  int errors = 0;
  int checks = 0;
  int tmo    = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int k, input int a, input int b, input int st, input int c);
    ev_t e;
    e    = '0;
    e.k  = 2'(k);
    e.a  = 12'(a);
    e.b  = 12'(b);
    e.st = 3'(st);
    e.c  = 3'(c);
    evq.push_back(e);
  endtask

  task automatic push_snap(input string n, input int ir, input int we, input int sw,
                           input int mv, input int dn, input int st, input int c,
                           input int a, input int b, input int m);
    snap_t s;
    s.ir = 1'(ir); s.we = 1'(we); s.sw = 1'(sw); s.mv = 1'(mv); s.dn = 1'(dn);
    s.st = 3'(st); s.c = 3'(c); s.a = 12'(a); s.b = 12'(b); s.m = 12'(m);
    snapq.push_back(s);
    snapn.push_back(n);
  endtask

  // Expected processing sweep: n cycles from the start of PROC.
  task automatic push_proc(input int n);
    int cnt;
    cnt = 0;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < DEPTH; i++)
        for (int s = 0; s < STAGES; s++) begin
          if (cnt < n)
            push_ev(1, c * DEPTH + i, c * DEPTH + ((i - LAG + DEPTH) % DEPTH), s, c);
          cnt++;
        end
  endtask

  // Monitor / scoreboard.
  initial begin
    ev_t   act, exp_e;
    snap_t sa, se;
    string sn;
    logic  have;
    forever begin
      @(negedge clk);
      have = 1'b0;
      act  = '0;
      if (wea) begin
        act.k = 2'd0; act.a = addra; have = 1'b1;
      end else if (m2_valid && m2_ready) begin
        act.k = 2'd2; act.a = m2_addr; have = 1'b1;
      end else if (done) begin
        act.k = 2'd3; have = 1'b1;
      end else if (switch && !m2_valid) begin
        act.k = 2'd1; act.a = addra; act.b = addrb; act.st = stage; act.c = ch; have = 1'b1;
      end
      if (have) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected: got kind=%0d a=%0d b=%0d st=%0d ch=%0d, want none",
                   act.k, act.a, act.b, act.st, act.c);
        end else begin
          exp_e = evq.pop_front();
          if (act !== exp_e) begin
            errors++;
            $display("FAIL event: got kind=%0d a=%0d b=%0d st=%0d ch=%0d, want kind=%0d a=%0d b=%0d st=%0d ch=%0d",
                     act.k, act.a, act.b, act.st, act.c,
                     exp_e.k, exp_e.a, exp_e.b, exp_e.st, exp_e.c);
          end
        end
      end
      if (snapq.size() > 0) begin
        se = snapq.pop_front();
        sn = snapn.pop_front();
        sa = {in_ready, wea, switch, m2_valid, done, stage, ch, addra, addrb, m2_addr};
        checks++;
        if (sa !== se) begin
          errors++;
          $display("FAIL %s: got ir=%0d we=%0d sw=%0d mv=%0d dn=%0d st=%0d ch=%0d a=%0d b=%0d m=%0d, want ir=%0d we=%0d sw=%0d mv=%0d dn=%0d st=%0d ch=%0d a=%0d b=%0d m=%0d",
                   sn, sa.ir, sa.we, sa.sw, sa.mv, sa.dn, sa.st, sa.c, sa.a, sa.b, sa.m,
                   se.ir, se.we, se.sw, se.mv, se.dn, se.st, se.c, se.a, se.b, se.m);
        end
      end
      if (end_req && !end_ack) begin
        checks++;
        if (evq.size() != 0 || tmo != 0) begin
          errors++;
          $display("FAIL drain: got pending_events=%0d timeouts=%0d, want 0 and 0", evq.size(), tmo);
        end
        end_ack = 1'b1;
      end
    end
  end

  // Stimulus.
  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; m2_ready = 1'b0;
    tick();
    tick();
    push_snap("reset_state", 0,0,0,0,0, 0,0, 0,0,0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    push_snap("idle_ignores_in_valid", 0,0,0,0,0, 0,0, 0,0,0);
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;

    // Frame 1: 16 back-to-back samples, full sweep, fetch with ready 1,0,0,1.
    for (int a = 0; a < NCH * DEPTH; a++) push_ev(0, a, 0, 0, 0);
    push_proc(NCH * DEPTH * STAGES);
    in_valid = 1'b1;
    push_snap("load_first", 1,1,0,0,0, 0,0, 0,0,0);
    for (int k = 0; k < NCH * DEPTH; k++) begin
      if (k == NCH * DEPTH - 1) push_snap("load_last", 1,1,0,0,0, 0,1, 15,0,0);
      tick();
    end
    push_snap("proc_first_switch", 0,0,1,0,0, 0,0, 0,6,0);
    tick();
    tick();
    in_valid = 1'b0;
    for (int a = 0; a < NCH * DEPTH; a++) push_ev(2, a, 0, 0, 0);
    push_ev(3, 0, 0, 0, 0);

    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      tick();
      if (m2_valid) seen = 1'b1;
    end
    if (!seen) tmo++;
    m2_ready = 1'b1;
    push_snap("fetch_c0", 0,0,1,1,0, 0,0, 0,0,0);
    tick();
    m2_ready = 1'b0;
    push_snap("fetch_c1_stall", 0,0,1,1,0, 0,0, 0,0,1);
    tick();
    push_snap("fetch_c2_stall", 0,0,1,1,0, 0,0, 0,0,1);
    tick();
    m2_ready = 1'b1;
    push_snap("fetch_c3", 0,0,1,1,0, 0,0, 0,0,1);
    for (int a = 2; a < NCH * DEPTH; a++) tick();
    tick();
    push_snap("done_pulse", 0,0,1,0,1, 0,0, 0,0,0);
    m2_ready = 1'b0;
    tick();
`ifdef ECG_ADDR_GEN_CONT_EN
    push_snap("after_done_cont_load", 1,0,0,0,0, 0,0, 0,0,0);
`else
    push_snap("after_done_idle", 0,0,0,0,0, 0,0, 0,0,0);
`endif

    // Frame 2: gap with a stray start in LOAD, then reset in PROC at i=5.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < NCH * DEPTH; a++) push_ev(0, a, 0, 0, 0);
    push_proc(31);
    in_valid = 1'b1;
    push_snap("load2_first", 1,1,0,0,0, 0,0, 0,0,0);
    for (int k = 0; k < 8; k++) tick();
    in_valid = 1'b0;
    start = 1'b1;
    push_snap("load2_gap_hold", 1,0,0,0,0, 0,1, 8,0,0);
    tick();
    start = 1'b0;
    push_snap("load2_start_ignored", 1,0,0,0,0, 0,1, 8,0,0);
    tick();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    in_valid = 1'b0;
    for (int k = 0; k < 31; k++) tick();
    rst_n = 1'b0;
    push_snap("reset_mid_proc", 0,0,0,0,0, 0,0, 0,0,0);
    tick();
    rst_n = 1'b1;
    push_snap("post_reset_idle", 0,0,0,0,0, 0,0, 0,0,0);
    tick();
    in_valid = 1'b1;
    push_snap("post_reset_needs_start", 0,0,0,0,0, 0,0, 0,0,0);
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    push_snap("restart_load_addr0", 1,0,0,0,0, 0,0, 0,0,0);
    tick();

    end_req = 1'b1;
    for (int w = 0; w < 5 && !end_ack; w++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL end_handshake: got no monitor acknowledge, want acknowledge");
      $fatal(1, "monitor stalled");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
